cal_addtree_sched: RTL and testbench

- Schedules multi-pass accumulation through the 9-input int18 adder tree (8 products + bias port, 2-cycle latency, no enable).
- Each output pixel needs cfg_npass passes, one per input-channel group.
- Pass 0 drives the real bias into the tree's bias port; later passes drive the pixel's stored partial sum.
- The final pass streams results to the output stage; sits between the PE array and the tree.

---
 rtl/cal_addtree_sched.sv | 166 ++++++++++++++++
 tb/tb_cal_addtree_sched.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cal_addtree_sched.sv
// cal_addtree_sched
// Schedules multi-pass accumulation through the external 9-input int18 adder
// tree (8 products + bias port, fixed 2-cycle latency, no enable). Each output
// pixel needs cfg_npass passes. Pass 0 feeds the real bias into the tree bias
// port; later passes feed back the pixel's stored partial sum. The last pass
// streams its results out with the pixel index.
//
// Optional feature: define CAL_ADDTREE_SCHED_RELU_EN to clamp negative
// final-pass results to 0 on the output register. Partial sums are never
// clamped and latency is unchanged.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   start                one-cycle job start (ignored while busy)
//   cfg_npix, cfg_npass  pixels per pass / passes per job, sampled on start
//   bias_in              signed bias, used on pass 0 only
//   in_valid, in_ready   beat handshake for the products on the tree inputs
//   tree_bias            combinational drive of the tree bias port
//   tree_dout            tree result, 2 cycles after the beat
//   out_valid/out_data/out_idx  final-pass result and its pixel index
//   busy, done           job active / one-cycle completion pulse
//   dbg_state            current FSM state (IDLE=0, RUN=1, DRAIN=2, FIN=3)
//
// Handshake: a beat transfers in every cycle where in_valid && in_ready are
// both high. in_ready depends only on internal state (never on in_valid), is
// low outside RUN, and drops for a cycle when the previous beat for the same
// pixel is still too deep in the tree to be forwarded. out_valid is a
// one-cycle qualifier with no back-pressure.
module cal_addtree_sched #(
  parameter int PIX_AW = 6,
  parameter int PASS_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [PIX_AW:0]   cfg_npix,
  input  logic [PASS_W-1:0] cfg_npass,
  input  logic [17:0]       bias_in,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [17:0]       tree_bias,
  input  logic [17:0]       tree_dout,
  output logic              out_valid,
  output logic [17:0]       out_data,
  output logic [PIX_AW-1:0] out_idx,
  output logic              busy,
  output logic              done,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, FIN = 2'd3} state_t;

  localparam logic [PIX_AW-1:0] IDX_ONE  = {{(PIX_AW-1){1'b0}}, 1'b1};
  localparam logic [PIX_AW:0]   NPIX_ONE = {{PIX_AW{1'b0}}, 1'b1};
  localparam logic [PASS_W-1:0] PASS_ONE = {{(PASS_W-1){1'b0}}, 1'b1};

  state_t              state, state_nx;
  logic [PIX_AW:0]     npix_q;
  logic [PASS_W-1:0]   npass_q;
  logic [PIX_AW-1:0]   pix_cnt;
  logic [PASS_W-1:0]   pass_cnt;

  // Valid pipe tracking beats in flight through the tree.
  logic                s1_v, s1_last, s2_v, s2_last;
  logic [PIX_AW-1:0]   s1_idx, s2_idx;

  logic [17:0]         psum_mem [0:(1<<PIX_AW)-1];

  logic                beat, pix_last, pass_last, hazard, fwd;

  assign beat      = in_valid & in_ready;
  assign pix_last  = ({1'b0, pix_cnt} == (npix_q - NPIX_ONE));
  assign pass_last = (pass_cnt == (npass_q - PASS_ONE));
  // Same pixel's previous beat is only one stage deep: its sum is not yet on
  // tree_dout, so it can be neither read from memory nor forwarded.
  assign hazard    = (pass_cnt != '0) && s1_v && (s1_idx == pix_cnt);
  // Previous beat for this pixel is leaving the tree right now.
  assign fwd       = s2_v && (s2_idx == pix_cnt);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (start) state_nx = ((cfg_npix == '0) || (cfg_npass == '0)) ? FIN : RUN;
      RUN:  if (beat && pix_last && pass_last) state_nx = DRAIN;
      // Once the pipe is empty the last out_valid has already been registered.
      DRAIN: if (!s1_v && !s2_v) state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Output logic
  always_comb begin
    in_ready  = (state == RUN) && !hazard;
    busy      = (state != IDLE);
    done      = (state == FIN);
    dbg_state = state;
    tree_bias = '0;
    if (state == RUN) begin
      if (pass_cnt == '0) tree_bias = bias_in;
      else if (fwd)       tree_bias = tree_dout;
      else                tree_bias = psum_mem[pix_cnt];
    end
  end

  // Counters, valid pipe and output register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      npix_q    <= '0;
      npass_q   <= '0;
      pix_cnt   <= '0;
      pass_cnt  <= '0;
      s1_v      <= 1'b0;
      s1_idx    <= '0;
      s1_last   <= 1'b0;
      s2_v      <= 1'b0;
      s2_idx    <= '0;
      s2_last   <= 1'b0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
    end else begin
      if (state == IDLE && start) begin
        npix_q   <= cfg_npix;
        npass_q  <= cfg_npass;
        pix_cnt  <= '0;
        pass_cnt <= '0;
      end else if (beat) begin
        if (pix_last) begin
          pix_cnt  <= '0;
          pass_cnt <= pass_cnt + PASS_ONE;
        end else begin
          pix_cnt  <= pix_cnt + IDX_ONE;
        end
      end
      s1_v      <= beat;
      s1_idx    <= pix_cnt;
      s1_last   <= pass_last;
      s2_v      <= s1_v;
      s2_idx    <= s1_idx;
      s2_last   <= s1_last;
      out_valid <= s2_v & s2_last;
      if (s2_v && s2_last) begin
        out_idx <= s2_idx;
`ifdef CAL_ADDTREE_SCHED_RELU_EN
        out_data <= tree_dout[17] ? '0 : tree_dout;
`else
        out_data <= tree_dout;
`endif
      end
    end
  end

  // Partial-sum buffer: contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (s2_v && !s2_last) psum_mem[s2_idx] <= tree_dout;
  end

endmodule

// File: tb/tb_cal_addtree_sched.sv
// Bench for cal_addtree_sched: directed table, hand-written reset sequence and
// randomized jobs checked against a pass-sum model of the accumulation.
module tb_cal_addtree_sched;
  localparam int PIX_AW = 6;
  localparam int PASS_W = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic              start = 1'b0;
  logic [PIX_AW:0]   cfg_npix = '0;
  logic [PASS_W-1:0] cfg_npass = '0;
  logic [17:0]       bias_in = '0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [17:0]       tree_bias;
  logic [17:0]       tree_dout;
  logic              out_valid;
  logic [17:0]       out_data;
  logic [PIX_AW-1:0] out_idx;
  logic              busy, done;
  logic [1:0]        dbg_state;

  cal_addtree_sched #(.PIX_AW(PIX_AW), .PASS_W(PASS_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .cfg_npix(cfg_npix),
    .cfg_npass(cfg_npass), .bias_in(bias_in), .in_valid(in_valid),
    .in_ready(in_ready), .tree_bias(tree_bias), .tree_dout(tree_dout),
    .out_valid(out_valid), .out_data(out_data), .out_idx(out_idx),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Adder tree environment: products collapse to one sum, 2-cycle latency.
  logic [17:0] prod_sum = '0;
  logic [17:0] tree_s1 = '0;
  logic [17:0] tree_s2 = '0;
  always @(posedge clk) begin
    tree_s1 <= prod_sum + tree_bias;
    tree_s2 <= tree_s1;
  end
  assign tree_dout = tree_s2;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  logic [PIX_AW+17:0] exp_q[$];
  logic [PIX_AW+17:0] sb_e;
  bit sb_en = 1'b1;
  int out_cnt = 0, last_out_cyc = 0, done_cnt = 0, done_cyc = 0;

  always @(negedge clk) begin
    if (out_valid) begin
      out_cnt++;
      last_out_cyc = cyc;
      if (sb_en) begin
        if (exp_q.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL out_unexpected: got idx %0d data %0h with nothing expected", out_idx, out_data);
        end else begin
          sb_e = exp_q.pop_front();
          check("out_idx", 32'(out_idx), 32'(sb_e[PIX_AW+17:18]));
          check("out_data", 32'(out_data), 32'(sb_e[17:0]));
        end
      end
    end
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // ---------------- stimulus data / model ----------------
  logic [17:0] prod_tab [0:7][0:63];

  function automatic logic [17:0] relu(input logic [17:0] v);
`ifdef CAL_ADDTREE_SCHED_RELU_EN
    return v[17] ? 18'd0 : v;
`else
    return v;
`endif
  endfunction

  // Final value of each pixel = bias + sum of its per-pass product sums.
  task automatic model_job(input int npix, input int npass, input logic [17:0] bias);
    logic [17:0] acc;
    for (int p = 0; p < npix; p++) begin
      acc = bias;
      for (int ps = 0; ps < npass; ps++) acc = acc + prod_tab[ps][p];
      exp_q.push_back({p[PIX_AW-1:0], relu(acc)});
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_job(input int npix, input int npass, input logic [17:0] bias,
                         input bit glitch, output int stalls);
    int tries;
    int beats;
    bit r;
    stalls = 0;
    beats = 0;
    @(negedge clk);
    cfg_npix = npix[PIX_AW:0];
    cfg_npass = npass[PASS_W-1:0];
    bias_in = bias;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int ps = 0; ps < npass && npix > 0; ps++) begin
      for (int px = 0; px < npix; px++) begin
        in_valid = 1'b1;
        prod_sum = prod_tab[ps][px];
        // bias_in must only matter on pass 0
        bias_in = (ps == 0) ? bias : 18'($urandom);
        tries = 0;
        do begin
          #1;
          r = in_ready;
          if (!r) stalls++;
          if (glitch && beats == 1 && r) begin
            start = 1'b1;
            cfg_npix = 7'd1;
            cfg_npass = 8'd1;
          end
          @(negedge clk);
          start = 1'b0;
          tries++;
        end while (!r && tries < 8);
        if (!r) begin
          n_vec++;
          n_err++;
          $display("FAIL beat_timeout: pass %0d pix %0d not accepted in 8 cycles", ps, px);
        end else begin
          beats++;
        end
      end
    end
    in_valid = 1'b0;
    prod_sum = '0;
  endtask

  task automatic wait_done(input int d0);
    int t = 0;
    while (done_cnt == d0 && t < 400) begin
      @(negedge clk);
      t++;
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic do_job(input string tag, input int npix, input int npass,
                        input logic [17:0] bias, input bit glitch, input int exp_stalls);
    int d0, o0, st;
    d0 = done_cnt;
    o0 = out_cnt;
    run_job(npix, npass, bias, glitch, st);
    wait_done(d0);
    check({tag, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    check({tag, "_out_count"}, 32'(out_cnt - o0), (npix > 0 && npass > 0) ? 32'(npix) : 32'd0);
    check({tag, "_stalls"}, 32'(st), 32'(exp_stalls));
    check({tag, "_exp_left"}, 32'(exp_q.size()), 32'd0);
    if (npix > 0 && npass > 0)
      check({tag, "_done_lag"}, 32'(done_cyc - last_out_cyc), 32'd1);
    check({tag, "_idle_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_idle_ready"}, {31'd0, in_ready}, 32'd0);
    exp_q.delete();
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    int npix;
    int npass;
    int bias;
    int prod;
    int exp_out;
    int exp_stalls;
    bit glitch;
  } vec_t;

  vec_t vecs[7];

  task automatic check_outputs_zero(input string tag);
    check({tag, "_out_valid"}, {31'd0, out_valid}, 32'd0);
    check({tag, "_out_data"}, 32'(out_data), 32'd0);
    check({tag, "_out_idx"}, 32'(out_idx), 32'd0);
    check({tag, "_busy"}, {31'd0, busy}, 32'd0);
    check({tag, "_done"}, {31'd0, done}, 32'd0);
    check({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_tree_bias"}, 32'(tree_bias), 32'd0);
    check({tag, "_state"}, 32'(dbg_state), 32'd0);
  endtask

  initial begin
    int d0, npix, npass;
    logic [17:0] b;

    vecs[0] = '{npix: 4, npass: 1, bias: 10, prod: 5, exp_out: 15, exp_stalls: 0, glitch: 1'b0};
    vecs[1] = '{npix: 4, npass: 3, bias: -7, prod: 100, exp_out: 293, exp_stalls: 0, glitch: 1'b0};
    vecs[2] = '{npix: 2, npass: 4, bias: 0, prod: 1, exp_out: 4, exp_stalls: 0, glitch: 1'b1};
    vecs[3] = '{npix: 1, npass: 3, bias: 2, prod: 3, exp_out: 11, exp_stalls: 2, glitch: 1'b0};
    vecs[4] = '{npix: 0, npass: 3, bias: 5, prod: 1, exp_out: 0, exp_stalls: 0, glitch: 1'b0};
    vecs[5] = '{npix: 3, npass: 0, bias: 5, prod: 1, exp_out: 0, exp_stalls: 0, glitch: 1'b0};
`ifdef CAL_ADDTREE_SCHED_RELU_EN
    vecs[6] = '{npix: 1, npass: 1, bias: -50, prod: 20, exp_out: 0, exp_stalls: 0, glitch: 1'b0};
`else
    vecs[6] = '{npix: 1, npass: 1, bias: -50, prod: 20, exp_out: -30, exp_stalls: 0, glitch: 1'b0};
`endif

    // reset state
    #1;
    check_outputs_zero("reset");
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      for (int ps = 0; ps < 8; ps++)
        for (int px = 0; px < 64; px++) prod_tab[ps][px] = 18'(vecs[v].prod);
      if (vecs[v].npix > 0 && vecs[v].npass > 0)
        for (int p = 0; p < vecs[v].npix; p++)
          exp_q.push_back({p[PIX_AW-1:0], 18'(vecs[v].exp_out)});
      do_job($sformatf("vec%0d", v), vecs[v].npix, vecs[v].npass,
             18'(vecs[v].bias), vecs[v].glitch, vecs[v].exp_stalls);
    end

    // Reset during pass 1 of an 8-pixel, 2-pass job: immediate clear, no done.
    for (int ps = 0; ps < 8; ps++)
      for (int px = 0; px < 64; px++) prod_tab[ps][px] = 18'($urandom);
    sb_en = 1'b0;
    d0 = done_cnt;
    @(negedge clk);
    cfg_npix = 7'd8;
    cfg_npass = 8'd2;
    bias_in = 18'd33;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int k = 0; k < 11; k++) begin
      in_valid = 1'b1;
      prod_sum = prod_tab[k / 8][k % 8];
      @(negedge clk);
    end
    #2 rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    in_valid = 1'b0;
    prod_sum = '0;
    repeat (4) @(negedge clk);
    check("midrst_no_done", 32'(done_cnt - d0), 32'd0);
    rst_n = 1'b1;
    exp_q.delete();
    sb_en = 1'b1;
    @(negedge clk);
    b = 18'($urandom);
    model_job(8, 2, b);
    do_job("post_rst", 8, 2, b, 1'b0, 0);

    // Randomized jobs against the model.
    for (int j = 0; j < 14; j++) begin
      if (j == 13) begin
        npix = 64;
        npass = 2;
      end else begin
        npix = $urandom_range(1, 12);
        npass = $urandom_range(1, 5);
      end
      for (int ps = 0; ps < 8; ps++)
        for (int px = 0; px < 64; px++) prod_tab[ps][px] = 18'($urandom);
      b = 18'($urandom);
      model_job(npix, npass, b);
      do_job($sformatf("rand%0d", j), npix, npass, b, 1'b0, (npix == 1) ? npass - 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err + 1);
    $fatal(1, "watchdog");
  end

endmodule
